fsic_io_serdes_tx: RTL and testbench

- Per-link transmit serializer. Takes one pDATA_WIDTH-bit parallel word per frame over a valid/ready handshake and drives it onto pDATA_WIDTH/pCLK_RATIO serial lanes, one bit per lane per ioclk cycle.
- Lane j carries word bits [j*pCLK_RATIO + phase], phase = 0..pCLK_RATIO-1. This is the bit order the fsic_io_serdes_rx lanes reassemble.
- Sits between the core-side packer and the pads. It also owns the frame phase counter and the clock-gate enable for serial_tclk.

---
 rtl/fsic_io_serdes_tx.sv | 135 +++++++++++++
 tb/tb_fsic_io_serdes_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsic_io_serdes_tx.sv
// fsic_io_serdes_tx: per-link transmit serializer.
//   Accepts one pDATA_WIDTH-bit word per frame through a one-deep hold register
//   (valid/ready), and shifts it onto pLANES = pDATA_WIDTH/pCLK_RATIO serial lanes.
//   Lane j carries word bit [j*pCLK_RATIO + phase] during phase 0..pCLK_RATIO-1.
// Ports:
//   ioclk, axis_rst         clock, async active-high reset
//   tx_en                   transmit enable request (sampled at word boundaries)
//   in_valid/in_data/in_ready  parallel word handshake into the hold register
//   underrun_clr            synchronous clear of underrun_cnt
//   serial_txd              lane data, gated by the transmit enable
//   serial_tclk_en          clock-gate enable for serial_tclk
//   phase_cnt               current bit phase within the frame
//   word_sent               pulse in the cycle after a real word is loaded
//   underrun_cnt            saturating count of idle frames sent while enabled
module fsic_io_serdes_tx #(
  parameter int pDATA_WIDTH = 32,
  parameter int pCLK_RATIO  = 4
) (
  input  logic                                ioclk,
  input  logic                                axis_rst,
  input  logic                                tx_en,
  input  logic                                in_valid,
  input  logic [pDATA_WIDTH-1:0]              in_data,
  output logic                                in_ready,
  input  logic                                underrun_clr,
  output logic [pDATA_WIDTH/pCLK_RATIO-1:0]   serial_txd,
  output logic                                serial_tclk_en,
  output logic [$clog2(pCLK_RATIO)-1:0]       phase_cnt,
  output logic                                word_sent,
  output logic [7:0]                          underrun_cnt
);

  localparam int pLANES = pDATA_WIDTH / pCLK_RATIO;
  localparam int PW     = $clog2(pCLK_RATIO);
  localparam logic [PW-1:0] LAST = PW'(pCLK_RATIO - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   txen_q;
  logic [PW-1:0]          phase_q, phase_d;
  logic [pDATA_WIDTH-1:0] shift_q, shift_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [pDATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [7:0]             underrun_q, underrun_d;
  logic                   word_sent_q, word_sent_d;

  logic boundary;
  logic load_real;
  logic load_idle;
  logic accept;

  assign boundary  = (phase_q == LAST);
  assign load_real = boundary & tx_en & hold_valid_q;
  assign load_idle = boundary & tx_en & ~hold_valid_q;
  assign in_ready  = ~hold_valid_q | load_real;
  assign accept    = in_valid & in_ready;

  // State register
  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: enable changes only take effect at word boundaries
  always_comb begin
    state_d = state_q;
    if (boundary) state_d = tx_en ? ST_RUN : ST_IDLE;
  end

  // State outputs
  always_comb begin
    txen_q = (state_q == ST_RUN);
  end

  // Datapath next-state
  always_comb begin
    phase_d      = phase_q + ONE;
    shift_d      = shift_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    underrun_d   = underrun_q;
    word_sent_d  = load_real;

    if (boundary) begin
      phase_d = tx_en ? '0 : LAST;
      shift_d = load_real ? hold_data_q : '0;
    end

    // Accept and consume can coincide: hold ends up with the new word, still valid
    if (load_real) hold_valid_d = 1'b0;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
    end

    if (underrun_clr)                        underrun_d = '0;
    else if (load_idle && underrun_q != '1)  underrun_d = underrun_q + 8'd1;
  end

  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) begin
      phase_q      <= LAST;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      underrun_q   <= '0;
      word_sent_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      underrun_q   <= underrun_d;
      word_sent_q  <= word_sent_d;
    end
  end

  // Each lane owns a contiguous pCLK_RATIO-bit slice of the word
  for (genvar j = 0; j < pLANES; j++) begin : g_lane
    logic [pCLK_RATIO-1:0] lane_bits;
    assign lane_bits     = shift_q[j*pCLK_RATIO +: pCLK_RATIO];
    assign serial_txd[j] = lane_bits[phase_q] & txen_q;
  end

  assign serial_tclk_en = txen_q;
  assign phase_cnt      = phase_q;
  assign word_sent      = word_sent_q;
  assign underrun_cnt   = underrun_q;

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// Directed bench for fsic_io_serdes_tx (pDATA_WIDTH=32, pCLK_RATIO=4, 8 lanes).
module tb_fsic_io_serdes_tx;

  logic        ioclk = 1'b0;
  logic        axis_rst;
  logic        tx_en;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        underrun_clr;
  logic [7:0]  serial_txd;
  logic        serial_tclk_en;
  logic [1:0]  phase_cnt;
  logic        word_sent;
  logic [7:0]  underrun_cnt;

  int checks = 0;
  int errors = 0;

  fsic_io_serdes_tx #(.pDATA_WIDTH(32), .pCLK_RATIO(4)) dut (
    .ioclk          (ioclk),
    .axis_rst       (axis_rst),
    .tx_en          (tx_en),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .underrun_clr   (underrun_clr),
    .serial_txd     (serial_txd),
    .serial_tclk_en (serial_tclk_en),
    .phase_cnt      (phase_cnt),
    .word_sent      (word_sent),
    .underrun_cnt   (underrun_cnt)
  );

  always #5 ioclk = ~ioclk;

  task automatic tick();
    @(posedge ioclk);
    #1;
  endtask

  // Hold a word with the link disabled (idle boundary, no underrun)
  task automatic preload(input logic [31:0] w);
    tx_en    = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1; tx_en = 1'b0; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0;
    #3;
    checks++; if (serial_txd !== 8'h00)   begin errors++; $display("FAIL rst_txd: got %h exp 00", serial_txd); end
    checks++; if (serial_tclk_en !== 1'b0) begin errors++; $display("FAIL rst_tclk: got %b exp 0", serial_tclk_en); end
    checks++; if (phase_cnt !== 2'd3)     begin errors++; $display("FAIL rst_phase: got %0d exp 3", phase_cnt); end
    checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL rst_ready: got %b exp 1", in_ready); end
    checks++; if (underrun_cnt !== 8'd0)  begin errors++; $display("FAIL rst_under: got %0d exp 0", underrun_cnt); end
    checks++; if (word_sent !== 1'b0)     begin errors++; $display("FAIL rst_ws: got %b exp 0", word_sent); end
    @(negedge ioclk);
    axis_rst = 1'b0;
    tick();
    checks++; if (phase_cnt !== 2'd3 || serial_tclk_en !== 1'b0)
      begin errors++; $display("FAIL idle_hold: phase %0d tclk %b exp 3/0", phase_cnt, serial_tclk_en); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4] = '{8'hAA, 8'hCC, 8'hF0, 8'h00};
    preload(32'h7654_3210);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_full: got %b exp 0", in_ready); end
    tx_en = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++; if (serial_txd !== exp_b[p])
        begin errors++; $display("FAIL basic_txd p%0d: got %h exp %h", p, serial_txd, exp_b[p]); end
      checks++; if (phase_cnt !== 2'(p))
        begin errors++; $display("FAIL basic_phase: got %0d exp %0d", phase_cnt, p); end
      checks++; if (word_sent !== (p == 0))
        begin errors++; $display("FAIL basic_ws p%0d: got %b exp %b", p, word_sent, p == 0); end
      checks++; if (serial_tclk_en !== 1'b1)
        begin errors++; $display("FAIL basic_tclk p%0d: got %b exp 1", p, serial_tclk_en); end
      if (p < 3) tick();
    end
    tx_en = 1'b0;
    tick();
    checks++; if (serial_tclk_en !== 1'b0 || serial_txd !== 8'h00 || phase_cnt !== 2'd3)
      begin errors++; $display("FAIL basic_stop: tclk %b txd %h phase %0d exp 0/00/3", serial_tclk_en, serial_txd, phase_cnt); end
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL basic_under: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000F};
    logic [7:0]  exp_l [3] = '{8'hFF, 8'h00, 8'h01};
    preload(words[0]);
    tx_en = 1'b1; in_valid = 1'b1; in_data = words[1];
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_bnd: got %b exp 1", in_ready); end
    for (int w = 0; w < 3; w++) begin
      tick();
      if (w == 0) in_data = words[2];
      if (w == 1) in_valid = 1'b0;
      for (int p = 0; p < 4; p++) begin
        checks++; if (serial_txd !== exp_l[w])
          begin errors++; $display("FAIL b2b_txd w%0d p%0d: got %h exp %h", w, p, serial_txd, exp_l[w]); end
        checks++; if (in_ready !== (p == 3 || w == 2))
          begin errors++; $display("FAIL b2b_ready w%0d p%0d: got %b exp %b", w, p, in_ready, p == 3 || w == 2); end
        if (p < 3) tick();
      end
    end
    tx_en = 1'b0;
    tick();
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL b2b_under: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_underrun();
    tx_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (serial_txd !== 8'h00 || word_sent !== 1'b0)
        begin errors++; $display("FAIL und_txd c%0d: txd %h ws %b exp 00/0", c, serial_txd, word_sent); end
    end
    tx_en = 1'b0;
    tick();
    checks++; if (underrun_cnt !== 8'd3) begin errors++; $display("FAIL und_cnt3: got %0d exp 3", underrun_cnt); end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL und_clr: got %0d exp 0", underrun_cnt); end
    tx_en = 1'b1; underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL und_clr_wins: got %0d exp 0", underrun_cnt); end
    for (int c = 0; c < 1200; c++) tick();
    checks++; if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL und_sat: got %0d exp 255", underrun_cnt); end
    tick(); tick(); tick();
    checks++; if (phase_cnt !== 2'd3) begin errors++; $display("FAIL und_phase: got %0d exp 3", phase_cnt); end
    tx_en = 1'b0;
    tick();
    checks++; if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL und_sat_hold: got %0d exp 255", underrun_cnt); end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL und_clr2: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_disable_midword();
    logic [7:0] exp_b [4] = '{8'hAA, 8'hCC, 8'hF0, 8'h00};
    preload(32'hFFFF_FFFF);
    tx_en = 1'b1;
    tick();
    checks++; if (serial_txd !== 8'hFF) begin errors++; $display("FAIL dis_p0: got %h exp ff", serial_txd); end
    in_valid = 1'b1; in_data = 32'h7654_3210;
    tick();
    in_valid = 1'b0; tx_en = 1'b0;
    for (int p = 1; p < 4; p++) begin
      checks++; if (serial_txd !== 8'hFF || serial_tclk_en !== 1'b1)
        begin errors++; $display("FAIL dis_tail p%0d: txd %h tclk %b exp ff/1", p, serial_txd, serial_tclk_en); end
      if (p < 3) tick();
    end
    tick();
    checks++; if (serial_tclk_en !== 1'b0 || phase_cnt !== 2'd3 || serial_txd !== 8'h00)
      begin errors++; $display("FAIL dis_idle: tclk %b phase %0d txd %h exp 0/3/00", serial_tclk_en, phase_cnt, serial_txd); end
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dis_hold: ready %b exp 0", in_ready); end
    tx_en = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++; if (serial_txd !== exp_b[p] || word_sent !== (p == 0))
        begin errors++; $display("FAIL dis_resume p%0d: txd %h ws %b exp %h/%b", p, serial_txd, word_sent, exp_b[p], p == 0); end
      if (p < 3) tick();
    end
    tx_en = 1'b0;
    tick();
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL dis_under: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_a [4] = '{8'hAA, 8'hCC, 8'hF0, 8'h00};
    preload(32'h7654_3210);
    tx_en = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      checks++; if (serial_txd !== exp_a[p])
        begin errors++; $display("FAIL sim_a p%0d: got %h exp %h", p, serial_txd, exp_a[p]); end
      checks++; if (in_ready !== (p == 3))
        begin errors++; $display("FAIL sim_hold p%0d: ready %b exp %b", p, in_ready, p == 3); end
      if (p < 3) tick();
    end
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++; if (serial_txd !== 8'hFF || word_sent !== (p == 0))
        begin errors++; $display("FAIL sim_b p%0d: txd %h ws %b exp ff/%b", p, serial_txd, word_sent, p == 0); end
      if (p < 3) tick();
    end
    tx_en = 1'b0;
    tick();
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL sim_under: got %0d exp 0", underrun_cnt); end
  endtask

  task automatic test_reset_midstream();
    tx_en = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    tick();
    checks++; if (serial_txd !== 8'hFF || underrun_cnt !== 8'd1)
      begin errors++; $display("FAIL mrst_pre: txd %h under %0d exp ff/1", serial_txd, underrun_cnt); end
    tick();
    #2 axis_rst = 1'b1;
    #1;
    checks++; if (serial_txd !== 8'h00 || serial_tclk_en !== 1'b0 || phase_cnt !== 2'd3 ||
                  in_ready !== 1'b1 || underrun_cnt !== 8'd0 || word_sent !== 1'b0)
      begin errors++; $display("FAIL mrst: txd %h tclk %b phase %0d ready %b under %0d ws %b exp 00/0/3/1/0/0",
                               serial_txd, serial_tclk_en, phase_cnt, in_ready, underrun_cnt, word_sent); end
    tx_en = 1'b0;
    @(negedge ioclk);
    axis_rst = 1'b0;
    tick();
    checks++; if (serial_tclk_en !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL mrst_after: tclk %b ready %b exp 0/1", serial_tclk_en, in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_disable_midword();
    test_simultaneous();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
